// File: rtl/slow_mem_resp_pkg.sv
// Shared definitions for the slow line memory responder and its cache clients.
package slow_mem_resp_pkg;

   localparam int unsigned LINE_W   = 128;
   localparam int unsigned ADDR_MSB = 31;
   localparam int unsigned ADDR_LSB = 4;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : slow_mem_resp_pkg

// File: rtl/slow_mem_array.sv
// Line storage: one synchronous write port, one combinational read port, no reset.
module slow_mem_array
   import slow_mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [LINE_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [LINE_W-1:0] rdata_c
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [LINE_W-1:0] mem [DEPTH];

   // Commit a line on the write strobe.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_c = mem[raddr];

endmodule : slow_mem_array

// File: rtl/slow_mem_resp.sv
// Fixed-latency line memory model answering one cache read/write at a time.
module slow_mem_resp
   import slow_mem_resp_pkg::*;
#(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned ADDR_W  = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [ADDR_MSB:ADDR_LSB] mem_addr,
   input  logic [LINE_W-1:0]      mem_wdata,
   output logic [LINE_W-1:0]      mem_rdata,
   output logic                   mem_ready
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               op_wr;
   logic [ADDR_W-1:0]  idx;
   logic [LINE_W-1:0]  wdata_q;
   logic [LINE_W-1:0]  rd_line_c;
   logic               we_c;

   // Address bits above the decoded line index alias and are dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^mem_addr[ADDR_MSB:ADDR_W+ADDR_LSB];

   // The write lands on the edge that ends the ready cycle (state DONE).
   assign we_c = (state == ST_DONE) && op_wr;

   slow_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we      (we_c),
      .waddr   (idx),
      .wdata   (wdata_q),
      .raddr   (idx),
      .rdata_c (rd_line_c)
   );

   // Request sequencer: accept, count down the latency, pulse ready, one dead cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         op_wr     <= 1'b0;
         idx       <= '0;
         wdata_q   <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_read || mem_write) begin
                  op_wr   <= mem_write;
                  idx     <= mem_addr[ADDR_W+ADDR_LSB-1:ADDR_LSB];
                  wdata_q <= mem_wdata;
                  cnt     <= CNT_W'(LATENCY - 1);
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  mem_ready <= 1'b1;
                  mem_rdata <= op_wr ? '0 : rd_line_c;
                  state     <= ST_DONE;
               end else begin
                  cnt <= CNT_W'(cnt - 1'b1);
               end
            end
            ST_DONE: begin
               mem_ready <= 1'b0;
               mem_rdata <= '0;
               state     <= ST_IDLE;
            end
            default: begin
               mem_ready <= 1'b0;
               mem_rdata <= '0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : slow_mem_resp
